// File: rtl/snn_upload_driver_if.sv
// Byte-stream interface between an upstream byte FIFO and the SNN upload
// driver.
//   s_data  : upstream byte
//   s_valid : upstream byte valid
//   s_ready : consumer can accept; a byte moves when s_valid & s_ready
// Modports: master = byte source (FIFO side), slave = byte sink (driver side).
interface snn_upload_driver_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/snn_upload_driver.sv
// Host-side sequencer for the spiking network's byte-wide upload port.
// A run optionally streams WEIGHT_BYTES weight bytes straight through to the
// network. It then collects INPUT_BYTES input bytes and bursts them
// back-to-back. Execute is held for EXEC_CYCLES cycles while the output spikes
// are counted. The per-neuron counts and the argmax winner are then reported.
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   start, load_weights begin a run (IDLE only); 1 = upload weights first
//   busy                high whenever the sequencer is not idle
//   up (slave)          upstream byte stream s_data/s_valid/s_ready
//   data_out            registered byte to the network's data_in
//   input_weights       registered weight-select pin (1 = weight register)
//   execute             registered execute pin (0 = network shifts data_in)
//   spikes              network output spike lines
//   result_valid        one-cycle pulse when a run completes
//   spike_counts        neuron n at [n*COUNT_BITS +: COUNT_BITS], saturating
//   winner              index of the largest count, lowest index on ties
module snn_upload_driver #(
  parameter int WEIGHT_BYTES = 80,
  parameter int INPUT_BYTES  = 2,
  parameter int EXEC_CYCLES  = 16,
  parameter int COUNT_BITS   = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    load_weights,
  output logic                    busy,
  snn_upload_driver_if.slave      up,
  output logic [7:0]              data_out,
  output logic                    input_weights,
  output logic                    execute,
  input  logic [7:0]              spikes,
  output logic                    result_valid,
  output logic [8*COUNT_BITS-1:0] spike_counts,
  output logic [2:0]              winner
);

  localparam int WB_W = $clog2(WEIGHT_BYTES + 1);
  localparam int IB_W = (INPUT_BYTES > 1) ? $clog2(INPUT_BYTES) : 1;
  localparam int EX_W = $clog2(EXEC_CYCLES + 1);

  localparam logic [WB_W-1:0]       WB_LAST   = WB_W'(WEIGHT_BYTES - 1);
  localparam logic [IB_W-1:0]       IB_LAST   = IB_W'(INPUT_BYTES - 1);
  localparam logic [EX_W-1:0]       EX_END    = EX_W'(EXEC_CYCLES);
  localparam logic [COUNT_BITS-1:0] COUNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WEIGHTS = 3'd1,
    INPUTS  = 3'd2,
    BURST   = 3'd3,
    EXEC    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t          state_reg;
  logic [WB_W-1:0] wcount_reg;
  logic [IB_W-1:0] icount_reg;
  logic [EX_W-1:0] ecount_reg;
  logic [7:0]      in_buf_reg [INPUT_BYTES];
  logic [7:0]      data_out_reg;
  logic            input_weights_reg;
  logic            execute_reg;
  logic            result_valid_reg;

  logic handshake;
  logic clear_counts;

  assign busy       = (state_reg != IDLE);
  assign up.s_ready = (state_reg == WEIGHTS) || (state_reg == INPUTS);
  assign handshake  = up.s_valid && up.s_ready;
  // Counters clear on the same edge that accepts a start.
  assign clear_counts = (state_reg == IDLE) && start;

  assign data_out      = data_out_reg;
  assign input_weights = input_weights_reg;
  assign execute       = execute_reg;
  assign result_valid  = result_valid_reg;

  // Network pins default to 0 on every cycle that does not explicitly drive
  // them. Any byte seen while execute=0 is shifted in by the network, so
  // idle cycles must present zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      wcount_reg        <= '0;
      icount_reg        <= '0;
      ecount_reg        <= '0;
      data_out_reg      <= '0;
      input_weights_reg <= 1'b0;
      execute_reg       <= 1'b0;
      result_valid_reg  <= 1'b0;
      for (int i = 0; i < INPUT_BYTES; i++) begin
        in_buf_reg[i] <= '0;
      end
    end else begin
      data_out_reg      <= '0;
      input_weights_reg <= 1'b0;
      execute_reg       <= 1'b0;
      result_valid_reg  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start) begin
            wcount_reg <= '0;
            icount_reg <= '0;
            state_reg  <= load_weights ? WEIGHTS : INPUTS;
          end
        end

        WEIGHTS: begin
          // Weight bytes go straight through. A stall cycle emits a zero
          // into the input register, which is reloaded before execute.
          if (handshake) begin
            data_out_reg      <= up.s_data;
            input_weights_reg <= 1'b1;
            if (wcount_reg == WB_LAST) begin
              wcount_reg <= '0;
              state_reg  <= INPUTS;
            end else begin
              wcount_reg <= wcount_reg + 1'b1;
            end
          end
        end

        INPUTS: begin
          // Inputs are buffered so that upstream stalls cannot open a gap
          // between the last input byte and execute.
          if (handshake) begin
            in_buf_reg[icount_reg] <= up.s_data;
            if (icount_reg == IB_LAST) begin
              icount_reg <= '0;
              state_reg  <= BURST;
            end else begin
              icount_reg <= icount_reg + 1'b1;
            end
          end
        end

        BURST: begin
          data_out_reg <= in_buf_reg[icount_reg];
          if (icount_reg == IB_LAST) begin
            icount_reg <= '0;
            ecount_reg <= '0;
            state_reg  <= EXEC;
          end else begin
            icount_reg <= icount_reg + 1'b1;
          end
        end

        EXEC: begin
          // Runs one extra cycle past the execute window. The final cycle
          // drops execute and raises result_valid, so the last spike sample
          // is already in the counters when the result is seen.
          if (ecount_reg == EX_END) begin
            result_valid_reg <= 1'b1;
            state_reg        <= DONE;
          end else begin
            execute_reg <= 1'b1;
            ecount_reg  <= ecount_reg + 1'b1;
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // One saturating counter per neuron. Counting is keyed to the registered
  // execute pin so that it matches exactly what the network sees.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_count
      logic [COUNT_BITS-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (reset || clear_counts) begin
          cnt_reg <= '0;
        end else if (execute_reg && spikes[gi] && (cnt_reg != COUNT_MAX)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign spike_counts[gi*COUNT_BITS +: COUNT_BITS] = cnt_reg;
    end
  endgenerate

  // Argmax over the live counters. A strict compare keeps the lowest index
  // on ties, and all-zero counts leave the winner at 0.
  logic [COUNT_BITS-1:0] best_val;
  logic [2:0]            best_idx;

  always_comb begin
    best_val = '0;
    best_idx = '0;
    for (int n = 0; n < 8; n++) begin
      if (spike_counts[n*COUNT_BITS +: COUNT_BITS] > best_val) begin
        best_val = spike_counts[n*COUNT_BITS +: COUNT_BITS];
        best_idx = 3'(n);
      end
    end
  end

  assign winner = best_idx;

endmodule

// File: tb/tb_snn_upload_driver.sv
// Self-checking bench for snn_upload_driver. Stimulus tasks push the expected
// network activity into scoreboard queues. A negedge monitor pops from the
// queues and compares whenever the DUT presents weight bytes, an execute
// window or a result. A second instance with 3-bit counters covers
// saturation.
module tb_snn_upload_driver;
  localparam int WB = 80;
  localparam int IB = 2;
  localparam int EC = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic load_weights = 1'b0;
  logic [7:0] spikes = 8'h00;
  logic busy, input_weights, execute, result_valid;
  logic [7:0] data_out;
  logic [39:0] spike_counts;
  logic [2:0] winner;

  logic start3 = 1'b0;
  logic [7:0] spikes3 = 8'h00;
  logic busy3, input_weights3, execute3, result_valid3;
  logic [7:0] data_out3;
  logic [23:0] spike_counts3;
  logic [2:0] winner3;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  snn_upload_driver_if up ();
  snn_upload_driver_if up3 ();

  snn_upload_driver #(.WEIGHT_BYTES(WB), .INPUT_BYTES(IB), .EXEC_CYCLES(EC), .COUNT_BITS(5)) dut (
    .clk(clk), .reset(reset), .start(start), .load_weights(load_weights), .busy(busy),
    .up(up.slave), .data_out(data_out), .input_weights(input_weights), .execute(execute),
    .spikes(spikes), .result_valid(result_valid), .spike_counts(spike_counts), .winner(winner)
  );

  snn_upload_driver #(.WEIGHT_BYTES(WB), .INPUT_BYTES(IB), .EXEC_CYCLES(EC), .COUNT_BITS(3)) dut_sat (
    .clk(clk), .reset(reset), .start(start3), .load_weights(1'b0), .busy(busy3),
    .up(up3.slave), .data_out(data_out3), .input_weights(input_weights3), .execute(execute3),
    .spikes(spikes3), .result_valid(result_valid3), .spike_counts(spike_counts3), .winner(winner3)
  );

  typedef struct { logic [7:0] data; int cyc; } wexp_t;
  typedef struct { logic [15:0] bytes; int cyc; } iexp_t;
  typedef struct { logic [39:0] counts; logic [2:0] win; int cyc; } rexp_t;

  wexp_t wq[$];
  iexp_t iq[$];
  rexp_t rq[$];

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: spikes seen during the execute window, summed per
  // neuron and clipped at maxv, then argmax with the lowest index on ties.
  function automatic logic [39:0] model_counts(input logic [7:0] spk[EC], input int maxv, input int cb);
    logic [39:0] res = '0;
    for (int n = 0; n < 8; n++) begin
      int c = 0;
      for (int t = 0; t < EC; t++) c += spk[t][n];
      if (c > maxv) c = maxv;
      res |= 40'(c) << (n * cb);
    end
    return res;
  endfunction

  function automatic logic [2:0] model_winner(input logic [39:0] counts, input int cb);
    int best = 0;
    int bi = 0;
    for (int n = 0; n < 8; n++) begin
      int c = int'((counts >> (n * cb)) & ((40'd1 << cb) - 1));
      if (c > best) begin best = c; bi = n; end
    end
    return 3'(bi);
  endfunction

  // Monitor: checks everything the DUT presents to the network.
  logic [7:0] p1_d = 0, p2_d = 0;
  logic p1_iw = 0, p2_iw = 0, p1_ex = 0, p2_ex = 0;
  int exec_len = 0;
  bit expect_idle = 0;

  always @(negedge clk) begin
    wexp_t we;
    iexp_t ie;
    rexp_t re;
    if (input_weights === 1'b1) begin
      if (wq.size() == 0) check("weight_unexpected", 1, 0);
      else begin
        we = wq.pop_front();
        check("weight_byte", data_out, we.data);
        check("weight_cycle", cyc, we.cyc);
      end
    end
    if (execute === 1'b1 && !p1_ex) begin
      exec_len = 0;
      if (iq.size() == 0) check("exec_unexpected", 1, 0);
      else begin
        ie = iq.pop_front();
        check("exec_rise_cycle", cyc, ie.cyc);
        check("burst_bytes", {p1_d, p2_d}, ie.bytes);
        check("burst_mode", {p1_iw, p1_ex, p2_iw, p2_ex}, 4'b0000);
      end
    end
    if (execute === 1'b1) begin
      exec_len++;
      check("exec_data_zero", data_out, 0);
    end
    if (execute !== 1'b1 && p1_ex) check("exec_len", exec_len, EC);
    if (result_valid === 1'b1) begin
      if (rq.size() == 0) check("result_unexpected", 1, 0);
      else begin
        re = rq.pop_front();
        check("result_cycle", cyc, re.cyc);
        check("spike_counts", spike_counts, re.counts);
        check("winner", winner, re.win);
        check("busy_at_result", busy, 1);
      end
      expect_idle = 1;
    end else if (expect_idle) begin
      check("busy_fall", busy, 0);
      expect_idle = 0;
    end
    p2_d = p1_d; p2_iw = p1_iw; p2_ex = p1_ex;
    p1_d = data_out; p1_iw = input_weights; p1_ex = (execute === 1'b1);
  end

  function automatic logic [7:0] junk(input int smode);
    return (smode == 0) ? 8'h00 : 8'($urandom);
  endfunction

  // One run. stall: 0 = s_valid always high, 1 = toggling, 2 = random.
  // smode: 0 = no spikes, 1 = constant 0x04, 2 = random, 3 = 0xFF.
  task automatic run(input bit lw, input int stall, input int smode, input bit fixed, input bit spam);
    logic [7:0] bts[$];
    logic [7:0] spk[EC];
    logic [39:0] cnt;
    int nw, total, idx, lastc, s0, to;
    bit tog, v;
    nw = lw ? WB : 0;
    total = nw + IB;
    for (int i = 0; i < nw; i++) bts.push_back(fixed ? 8'(i + 1) : 8'($urandom));
    bts.push_back(fixed ? 8'hA5 : 8'($urandom));
    bts.push_back(fixed ? 8'h3C : 8'($urandom));
    for (int t = 0; t < EC; t++)
      spk[t] = (smode == 0) ? 8'h00 : (smode == 1) ? 8'h04 : (smode == 3) ? 8'hFF : 8'($urandom);
    cnt = model_counts(spk, 31, 5);

    @(negedge clk);
    check("busy_before_start", busy, 0);
    start = 1'b1; load_weights = lw; spikes = junk(smode); s0 = cyc;
    @(negedge clk);
    start = spam;
    check("busy_after_start", busy, 1);
    idx = 0; lastc = 0; to = 0; tog = 1;
    forever begin
      v = (stall == 0) ? 1'b1 : (stall == 1) ? tog : 1'($urandom);
      tog = ~tog;
      up.s_valid = v;
      up.s_data = v ? bts[idx] : 8'($urandom);
      spikes = junk(smode);
      if (v && up.s_ready) begin
        if (idx < nw) wq.push_back('{bts[idx], cyc + 1});
        lastc = cyc;
        idx++;
      end
      if (idx == total) break;
      @(negedge clk);
      to++;
      if (to > 3000) begin
        check("handshake_timeout", idx, total);
        break;
      end
    end
    iq.push_back('{{bts[total-1], bts[total-2]}, lastc + IB + 2});
    rq.push_back('{cnt, model_winner(cnt, 5), lastc + IB + EC + 2});
    if (stall == 0) check("capture_cycle", lastc - s0, lw ? (WB + IB) : IB);
    for (int k = 1; k <= IB + EC + 1; k++) begin
      @(negedge clk);
      up.s_valid = 1'b0;
      start = spam && (k <= IB + EC);
      spikes = (k >= IB + 2 && k <= IB + EC + 1) ? spk[k - IB - 2] : junk(smode);
    end
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      spikes = junk(smode);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_s_ready"}, up.s_ready, 0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_input_weights"}, input_weights, 0);
    check({tag, "_execute"}, execute, 0);
    check({tag, "_result_valid"}, result_valid, 0);
    check({tag, "_spike_counts"}, spike_counts, 0);
    check({tag, "_winner"}, winner, 0);
  endtask

  // Reset after 40 weight bytes have been accepted.
  task automatic partial_reset();
    int n = 0;
    int to = 0;
    logic [7:0] b;
    @(negedge clk);
    start = 1'b1; load_weights = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (n < 40 && to < 500) begin
      b = 8'($urandom);
      up.s_valid = 1'b1; up.s_data = b;
      if (up.s_ready) begin wq.push_back('{b, cyc + 1}); n++; end
      @(negedge clk);
      to++;
    end
    check("partial_bytes", n, 40);
    up.s_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    check_idle("mid_reset");
    reset = 1'b0;
  endtask

  // Saturation instance: 3-bit counters, inputs only.
  task automatic run_sat(input int smode);
    logic [7:0] spk[EC];
    logic [39:0] cnt;
    int n, lastc, to;
    bit got;
    for (int t = 0; t < EC; t++) spk[t] = (smode == 3) ? 8'hFF : 8'($urandom);
    cnt = model_counts(spk, 7, 3);
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    n = 0; lastc = 0; to = 0;
    while (n < IB && to < 100) begin
      up3.s_valid = 1'b1; up3.s_data = 8'($urandom);
      if (up3.s_ready) begin lastc = cyc; n++; end
      if (n < IB) begin @(negedge clk); to++; end
    end
    check("sat_capture", n, IB);
    for (int k = 1; k <= IB + EC + 1; k++) begin
      @(negedge clk);
      up3.s_valid = 1'b0;
      spikes3 = (k >= IB + 2 && k <= IB + EC + 1) ? spk[k - IB - 2] : 8'($urandom);
    end
    got = 0;
    for (int w = 0; w < 10 && !got; w++) begin
      @(negedge clk);
      spikes3 = 8'($urandom);
      if (result_valid3 === 1'b1) begin
        got = 1;
        check("sat_result_cycle", cyc, lastc + IB + EC + 2);
        check("sat_counts", spike_counts3, cnt[23:0]);
        check("sat_winner", winner3, model_winner(cnt, 3));
      end
    end
    if (!got) check("sat_result_timeout", 0, 1);
    spikes3 = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    up.s_valid = 1'b0; up.s_data = 8'h00;
    up3.s_valid = 1'b0; up3.s_data = 8'h00;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;

    run(1'b1, 0, 0, 1'b1, 1'b0);
    run(1'b1, 1, 2, 1'b0, 1'b0);
    run(1'b0, 0, 1, 1'b0, 1'b0);
    partial_reset();
    run(1'b1, 2, 2, 1'b0, 1'b0);
    run(1'b0, 2, 2, 1'b0, 1'b1);
    run(1'b1, 0, 2, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) run(1'($urandom), 2, 2, 1'b0, 1'($urandom));

    run_sat(3);
    run_sat(2);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", wq.size() + iq.size() + rq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
